pixel_word_pack: RTL and testbench



---
 rtl/pixel_pkg.sv | 10 +
 rtl/axis_if.sv | 14 +
 rtl/pixel_word_pack.sv | 129 ++++++++++++
 tb/tb_pixel_word_pack.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel/word types for the output packing stage.
package pixel_pkg;

    typedef logic [7:0]  pixel_t;
    typedef logic [31:0] word_t;

    localparam int PIX_PER_WORD = 4;
    localparam int LANE_W       = 2;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream style bundle: data, valid, ready, last.
interface axis_if #(
    parameter int W = 8
) ();

    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/pixel_word_pack.sv
// Packs four 8-bit pixels little-endian into a 32-bit word, closes each
// frame with last on the final word (zero-padding a partial word) and
// flags frames whose input last disagrees with the configured size.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready
// are both 1. A master holds valid, data and last stable while valid=1 and
// ready=0; valid never depends combinationally on ready.
module pixel_word_pack
    import pixel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic   clk,
    input  logic   rst,
    axis_if.slave  axis_i,
    axis_if.master axis_o,
    output logic   frame_done,
    output logic   err
);

    localparam int N      = IMG_W * IMG_H;
    localparam int PCNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(N - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    word_t             acc_q, acc_d;
    word_t             out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic  terminal;
    logic  completing;
    logic  end_of_frame;
    logic  in_ready;
    logic  in_fire;
    logic  out_fire;
    word_t merged;

    // Completion/handshake decode and the accumulator with the incoming pixel merged in.
    always_comb begin
        terminal     = (pcnt_q == PCNT_LAST);
        completing   = (lane_q == LANE_LAST) || terminal || axis_i.last;
        end_of_frame = terminal || axis_i.last;
        // Only a completing pixel needs the output register; others never stall.
        in_ready     = !out_valid_q || axis_o.ready || !completing;
        in_fire      = axis_i.valid && in_ready;
        out_fire     = out_valid_q && axis_o.ready;
        // Accumulator lanes above lane_q are always zero, so a partial word pads itself.
        merged       = acc_q;
        merged[{lane_q, 3'b000} +: 8] = pixel_t'(axis_i.data);
    end

    // Next-state for counters, accumulator, output register and status flags.
    always_comb begin
        lane_d       = lane_q;
        pcnt_d       = pcnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        err_d        = err_q;
        frame_done_d = out_fire && out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            if (completing) begin
                // Takes priority over the drain above: accept and reload on one edge.
                out_data_d  = merged;
                out_last_d  = end_of_frame;
                out_valid_d = 1'b1;
                lane_d      = '0;
                acc_d       = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                acc_d  = merged;
            end

            if (end_of_frame) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end

            // Short frame (early last) or long frame (no last on terminal pixel).
            if (axis_i.last != terminal) begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial or pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q       <= '0;
            pcnt_q       <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            pcnt_q       <= pcnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign axis_i.ready = in_ready;
    assign axis_o.data  = out_data_q;
    assign axis_o.valid = out_valid_q;
    assign axis_o.last  = out_last_q;
    assign frame_done   = frame_done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pixel_word_pack.sv
// Bench for pixel_word_pack: three instances (4x2, 3x1, 5x3), a negedge
// monitor collecting accepted output words, and a frame-level packing model.
module tb_pixel_word_pack;
    import pixel_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring (index 0: 4x2, 1: 3x1, 2: 5x3) ----------------
    logic [2:0] in_valid;
    logic [2:0] in_last;
    logic [2:0] out_ready;
    logic [7:0] in_data [3];

    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  out_last;
    wire  [2:0]  fd;
    wire  [2:0]  er;
    wire  [31:0] out_data [3];

    axis_if #(.W(8))  ai0 ();
    axis_if #(.W(8))  ai1 ();
    axis_if #(.W(8))  ai2 ();
    axis_if #(.W(32)) ao0 ();
    axis_if #(.W(32)) ao1 ();
    axis_if #(.W(32)) ao2 ();

    assign ai0.valid = in_valid[0];
    assign ai0.data  = in_data[0];
    assign ai0.last  = in_last[0];
    assign ao0.ready = out_ready[0];
    assign ai1.valid = in_valid[1];
    assign ai1.data  = in_data[1];
    assign ai1.last  = in_last[1];
    assign ao1.ready = out_ready[1];
    assign ai2.valid = in_valid[2];
    assign ai2.data  = in_data[2];
    assign ai2.last  = in_last[2];
    assign ao2.ready = out_ready[2];

    assign in_ready  = {ai2.ready, ai1.ready, ai0.ready};
    assign out_valid = {ao2.valid, ao1.valid, ao0.valid};
    assign out_last  = {ao2.last, ao1.last, ao0.last};
    assign out_data[0] = ao0.data;
    assign out_data[1] = ao1.data;
    assign out_data[2] = ao2.data;

    pixel_word_pack #(.IMG_W(4), .IMG_H(2)) dut_a (
        .clk(clk), .rst(rst), .axis_i(ai0), .axis_o(ao0),
        .frame_done(fd[0]), .err(er[0])
    );
    pixel_word_pack #(.IMG_W(3), .IMG_H(1)) dut_b (
        .clk(clk), .rst(rst), .axis_i(ai1), .axis_o(ao1),
        .frame_done(fd[1]), .err(er[1])
    );
    pixel_word_pack #(.IMG_W(5), .IMG_H(3)) dut_c (
        .clk(clk), .rst(rst), .axis_i(ai2), .axis_o(ao2),
        .frame_done(fd[2]), .err(er[2])
    );

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q [3][$];   // {last, word}
    logic [32:0] got_q [3][$];
    logic [7:0]  frame_px[$];
    int          fd_cnt [3];
    int          checks = 0;
    int          errors = 0;

    // Inputs change at posedge+#1, so at negedge valid&ready predicts the next edge's transfer.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d] && out_ready[d])
                    got_q[d].push_back({out_last[d], out_data[d]});
                if (fd[d])
                    fd_cnt[d]++;
            end
        end
    end

    // Reference: a frame of n pixels becomes ceil(n/4) words, pixel i in byte i%4
    // of word i/4, missing bytes zero, last on the final word only.
    task automatic model_frame(input int d);
        int n;
        int nw;
        logic [31:0] w;
        n  = frame_px.size();
        nw = (n + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * j + k < n)
                    w = w | (32'(frame_px[4 * j + k]) << (8 * k));
            exp_q[d].push_back({(j == nw - 1), w});
        end
        frame_px.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_sb(input int d);
        exp_q[d].delete();
        got_q[d].delete();
        fd_cnt[d] = 0;
    endtask

    task automatic send(input int d, input logic [7:0] data, input logic last,
                        output int stalls);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        stalls = 0;
        @(negedge clk);
        while (!in_ready[d] && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut %0d data %h: ready stayed 0, required 1", d, data);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic drain(input int d, input int n);
        int cyc;
        cyc = 0;
        while (got_q[d].size() < n && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid  = '0;
        in_last   = '0;
        out_ready = '1;
        for (int d = 0; d < 3; d++) in_data[d] = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({out_valid[d], out_last[d], fd[d], er[d]} !== 4'b0 || out_data[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs dut %0d: valid %b last %b fd %b err %b data %h, required all 0",
                         d, out_valid[d], out_last[d], fd[d], er[d], out_data[d]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 111", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int st;
        int tot;
        clear_sb(0);
        out_ready[0] = 1'b1;
        tot = 0;
        for (int i = 1; i <= 8; i++) begin
            frame_px.push_back(8'(i));
            send(0, 8'(i), (i == 8), st);
            tot += st;
        end
        model_frame(0);
        drain(0, 2);
        checks++;
        if (tot !== 0) begin
            errors++;
            $display("FAIL basic_stalls: got %0d, required 0", tot);
        end
        checks++;
        if (got_q[0].size() !== exp_q[0].size()) begin
            errors++;
            $display("FAIL basic_count: got %0d words, required %0d", got_q[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            checks++;
            if (got_q[0][i] !== exp_q[0][i]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h, required %h", i, got_q[0][i], exp_q[0][i]);
            end
        end
        checks++;
        if (fd_cnt[0] !== 1 || er[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: frame_done count %0d err %b, required 1 and 0", fd_cnt[0], er[0]);
        end
    endtask

    task automatic test_stall();
        int st;
        int tot;
        int st8;
        clear_sb(0);
        out_ready[0] = 1'b0;
        tot = 0;
        for (int i = 1; i <= 8; i++) frame_px.push_back(8'(i));
        model_frame(0);
        for (int i = 1; i <= 7; i++) begin
            send(0, 8'(i), 1'b0, st);
            tot += st;
        end
        st8 = 0;
        fork
            send(0, 8'h08, 1'b1, st8);
            begin
                repeat (6) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid[0] !== 1'b1 || out_data[0] !== exp_q[0][0][31:0]) begin
                        errors++;
                        $display("FAIL stall_hold: valid %b data %h, required 1 and %h",
                                 out_valid[0], out_data[0], exp_q[0][0][31:0]);
                    end
                end
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        drain(0, 2);
        checks++;
        if (tot !== 0 || st8 !== 6) begin
            errors++;
            $display("FAIL stall_ready: stalls on 1..7 %0d, on 0x08 %0d, required 0 and 6", tot, st8);
        end
        checks++;
        if (got_q[0].size() !== exp_q[0].size()) begin
            errors++;
            $display("FAIL stall_count: got %0d words, required %0d", got_q[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            checks++;
            if (got_q[0][i] !== exp_q[0][i]) begin
                errors++;
                $display("FAIL stall_word%0d: got %h, required %h", i, got_q[0][i], exp_q[0][i]);
            end
        end
        checks++;
        if (fd_cnt[0] !== 1) begin
            errors++;
            $display("FAIL stall_frame_done: got %0d pulses, required 1", fd_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        int st;
        clear_sb(0);
        // Leave a word pending in the output register plus a partial accumulator.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 8'(8'h11 * (i + 1)), 1'b0, st);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid[0], out_last[0], fd[0], er[0]} !== 4'b0 || out_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: valid %b last %b fd %b err %b data %h, required all 0",
                     out_valid[0], out_last[0], fd[0], er[0], out_data[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            frame_px.push_back(8'(i));
            send(0, 8'(i), (i == 8), st);
        end
        model_frame(0);
        drain(0, 2);
        checks++;
        if (got_q[0].size() !== exp_q[0].size()) begin
            errors++;
            $display("FAIL midreset_count: got %0d words, required %0d", got_q[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            checks++;
            if (got_q[0][i] !== exp_q[0][i]) begin
                errors++;
                $display("FAIL midreset_word%0d: got %h, required %h", i, got_q[0][i], exp_q[0][i]);
            end
        end
    endtask

    task automatic test_partial();
        int st;
        logic [7:0] px [3];
        px[0] = 8'hAA;
        px[1] = 8'hBB;
        px[2] = 8'hCC;
        clear_sb(1);
        out_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_px.push_back(px[i]);
            send(1, px[i], (i == 2), st);
        end
        model_frame(1);
        drain(1, 1);
        checks++;
        if (got_q[1].size() !== 1 || got_q[1][0] !== exp_q[1][0]) begin
            errors++;
            $display("FAIL partial_word: got %0d words first %h, required 1 word %h",
                     got_q[1].size(), got_q[1][0], exp_q[1][0]);
        end
        checks++;
        if (fd_cnt[1] !== 1 || er[1] !== 1'b0) begin
            errors++;
            $display("FAIL partial_status: frame_done count %0d err %b, required 1 and 0", fd_cnt[1], er[1]);
        end
    endtask

    task automatic test_random();
        int st;
        logic done;
        logic [7:0] p;
        clear_sb(2);
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 100; f++) begin
                    for (int i = 0; i < 15; i++) begin
                        if ($urandom_range(0, 1) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        p = 8'($urandom_range(0, 255));
                        frame_px.push_back(p);
                        send(2, p, (i == 14), st);
                    end
                    model_frame(2);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready[2] = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready[2] = 1'b1;
        drain(2, 400);
        checks++;
        if (got_q[2].size() !== 400 || exp_q[2].size() !== 400) begin
            errors++;
            $display("FAIL random_count: got %0d words, model %0d, required 400", got_q[2].size(), exp_q[2].size());
        end
        for (int i = 0; i < exp_q[2].size(); i++) begin
            checks++;
            if (got_q[2][i] !== exp_q[2][i]) begin
                errors++;
                $display("FAIL random_word%0d: got %h, required %h", i, got_q[2][i], exp_q[2][i]);
            end
        end
        checks++;
        if (fd_cnt[2] !== 100 || er[2] !== 1'b0) begin
            errors++;
            $display("FAIL random_status: frame_done count %0d err %b, required 100 and 0", fd_cnt[2], er[2]);
        end
    endtask

    task automatic test_short();
        int st;
        clear_sb(0);
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            frame_px.push_back(8'(i));
            send(0, 8'(i), (i == 5), st);
        end
        model_frame(0);
        drain(0, 2);
        checks++;
        if (er[0] !== 1'b1) begin
            errors++;
            $display("FAIL short_err: got %b, required 1", er[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            frame_px.push_back(8'(8'h20 + i));
            send(0, 8'(8'h20 + i), (i == 8), st);
        end
        model_frame(0);
        drain(0, 4);
        checks++;
        if (got_q[0].size() !== exp_q[0].size()) begin
            errors++;
            $display("FAIL short_count: got %0d words, required %0d", got_q[0].size(), exp_q[0].size());
        end
        for (int i = 0; i < exp_q[0].size(); i++) begin
            checks++;
            if (got_q[0][i] !== exp_q[0][i]) begin
                errors++;
                $display("FAIL short_word%0d: got %h, required %h", i, got_q[0][i], exp_q[0][i]);
            end
        end
        checks++;
        if (er[0] !== 1'b1 || fd_cnt[0] !== 2) begin
            errors++;
            $display("FAIL short_sticky: err %b frame_done count %0d, required 1 and 2", er[0], fd_cnt[0]);
        end
    endtask

    task automatic test_long();
        int st;
        clear_sb(1);
        out_ready[1] = 1'b1;
        // Terminal pixel without last closes the frame; the following pixels form a new one.
        for (int i = 0; i < 3; i++) begin
            frame_px.push_back(8'(8'h31 + i));
            send(1, 8'(8'h31 + i), 1'b0, st);
        end
        model_frame(1);
        for (int i = 0; i < 3; i++) begin
            frame_px.push_back(8'(8'h34 + i));
            send(1, 8'(8'h34 + i), (i == 2), st);
        end
        model_frame(1);
        drain(1, 2);
        checks++;
        if (got_q[1].size() !== exp_q[1].size()) begin
            errors++;
            $display("FAIL long_count: got %0d words, required %0d", got_q[1].size(), exp_q[1].size());
        end
        for (int i = 0; i < exp_q[1].size(); i++) begin
            checks++;
            if (got_q[1][i] !== exp_q[1][i]) begin
                errors++;
                $display("FAIL long_word%0d: got %h, required %h", i, got_q[1][i], exp_q[1][i]);
            end
        end
        checks++;
        if (er[1] !== 1'b1) begin
            errors++;
            $display("FAIL long_err: got %b, required 1", er[1]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int d = 0; d < 3; d++) fd_cnt[d] = 0;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_partial();
        test_random();
        test_short();
        test_long();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
